mod_period_detect: RTL and testbench

Receive-side counterpart to the transducer modulation generator. It samples an external modulation square wave and measures its half period in the same tick units the generator uses (one tick per 2^COUNTER_WIDTH clocks). Once the measurement is stable, it presents the result on a `mod_half_period` / `mod_set` pair that can drive a local modulation generator directly. A secondary board can therefore reproduce the master's AM envelope without a register write.

---
 rtl/mod_period_detect.sv | 178 +++++++++++++++++
 tb/tb_mod_period_detect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_period_detect.sv
// Purpose: measure the half period of an external modulation square wave in prescaler ticks and lock onto it.
// Latency: a mod_in transition sampled at clk edge k updates mod_set/mod_half_period/locked at edge k+3.
// Backpressure: none; mod_set is a single-cycle strobe that the consumer must take when it fires.
module mod_period_detect #(
    parameter int COUNTER_WIDTH = 2,
    parameter int MATCH_COUNT   = 3,
    parameter int TOLERANCE     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mod_in,
    output logic [15:0] mod_half_period,
    output logic        mod_set,
    output logic        locked,
    output logic        mod_level
);

    localparam logic [15:0] TOL     = 16'(TOLERANCE);
    localparam logic [3:0]  MATCH_N = 4'(MATCH_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sync0;
    logic        sync1;
    logic        sync_prev;
    logic        mod_edge;
    logic        tick;
    logic [15:0] ivl;
    logic        timeout;
    logic [15:0] ref_q;
    logic [15:0] ref_nxt;
    logic [3:0]  match_cnt;
    logic [3:0]  match_nxt;
    logic [3:0]  match_inc;
    logic [15:0] half_nxt;
    logic        set_nxt;
    logic        locked_nxt;

    // Unsigned distance compared in both orderings so nothing wraps.
    function automatic logic within_tol(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= TOL);
    endfunction

    assign mod_level = sync1;
    assign timeout   = (ivl == 16'hFFFF);
    assign match_inc = match_cnt + 4'd1;

    // Two-flop synchronizer, previous-level flop and a registered edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            sync_prev <= 1'b0;
            mod_edge  <= 1'b0;
        end else begin
            sync0     <= mod_in;
            sync1     <= sync0;
            sync_prev <= sync1;
            mod_edge  <= sync1 ^ sync_prev;
        end
    end

    // Free-running prescaler; a zero-width prescaler ticks every clock.
    generate
        if (COUNTER_WIDTH == 0) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            logic [COUNTER_WIDTH-1:0] presc;

            // Prescaler counter wraps naturally; tick while it is all ones.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    presc <= '0;
                end else begin
                    presc <= presc + COUNTER_WIDTH'(1);
                end
            end

            assign tick = &presc;
        end
    endgenerate

    // Interval counter: cleared on an edge (dropping a coincident tick), saturates at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ivl <= 16'd0;
        end else if (mod_edge) begin
            ivl <= 16'd0;
        end else if (tick && !timeout) begin
            ivl <= ivl + 16'd1;
        end
    end

    // State and measurement registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            ref_q           <= 16'd0;
            match_cnt       <= 4'd0;
            mod_half_period <= 16'd0;
            mod_set         <= 1'b0;
            locked          <= 1'b0;
        end else begin
            state           <= state_nxt;
            ref_q           <= ref_nxt;
            match_cnt       <= match_nxt;
            mod_half_period <= half_nxt;
            mod_set         <= set_nxt;
            locked          <= locked_nxt;
        end
    end

    // Next-state logic; the counter value seen on an edge cycle is the measurement.
    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_q;
        match_nxt  = match_cnt;
        half_nxt   = mod_half_period;
        set_nxt    = 1'b0;
        locked_nxt = locked;

        if (timeout) begin
            // Lost modulation: fall back to idle and announce "no modulation" once.
            state_nxt  = ST_IDLE;
            locked_nxt = 1'b0;
            if (mod_half_period != 16'd0) begin
                half_nxt = 16'd0;
                set_nxt  = 1'b1;
            end
        end else if (mod_edge) begin
            case (state)
                ST_IDLE: begin
                    // Interval start unknown until now, so just arm.
                    state_nxt = ST_ACQUIRE;
                    match_nxt = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (ivl == 16'd0) begin
                        match_nxt = 4'd0;
                    end else if (match_cnt == 4'd0 || !within_tol(ivl, ref_q)) begin
                        ref_nxt   = ivl;
                        match_nxt = 4'd1;
                    end else begin
                        match_nxt = match_inc;
                        if (match_inc == MATCH_N) begin
                            half_nxt   = ref_q;
                            set_nxt    = 1'b1;
                            locked_nxt = 1'b1;
                            state_nxt  = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    // The published value stays put until a fresh lock replaces it.
                    if (!within_tol(ivl, mod_half_period)) begin
                        locked_nxt = 1'b0;
                        ref_nxt    = ivl;
                        match_nxt  = (ivl == 16'd0) ? 4'd0 : 4'd1;
                        state_nxt  = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_period_detect.sv
// Directed bench for mod_period_detect: a default instance for lock/relock behaviour and a
// zero-width-prescaler instance so the 65535-tick timeout fits in a short run.
module tb_mod_period_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mod_in = 1'b0;
    logic [15:0] hp;
    logic        set;
    logic        lk;
    logic        lvl;

    logic        rst_n_f = 1'b0;
    logic        mod_in_f = 1'b0;
    logic [15:0] hp_f;
    logic        set_f;
    logic        lk_f;
    logic        lvl_f;

    int errors = 0;
    int checks = 0;
    int set_cnt = 0;
    int set_cnt_f = 0;
    int set_consec = 0;
    int hp_bad = 0;
    logic        set_prev = 1'b0;
    logic        set_prev_f = 1'b0;
    logic [15:0] hp_prev = 16'd0;
    logic [15:0] hp_prev_f = 16'd0;

    always #5 clk = ~clk;

    mod_period_detect u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mod_in          (mod_in),
        .mod_half_period (hp),
        .mod_set         (set),
        .locked          (lk),
        .mod_level       (lvl)
    );

    mod_period_detect #(.COUNTER_WIDTH(0), .MATCH_COUNT(3), .TOLERANCE(1)) u_fast (
        .clk             (clk),
        .rst_n           (rst_n_f),
        .mod_in          (mod_in_f),
        .mod_half_period (hp_f),
        .mod_set         (set_f),
        .locked          (lk_f),
        .mod_level       (lvl_f)
    );

    // Observe strobes just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (set === 1'b1) set_cnt <= set_cnt + 1;
        if (set_f === 1'b1) set_cnt_f <= set_cnt_f + 1;
        if ((set === 1'b1 && set_prev === 1'b1) || (set_f === 1'b1 && set_prev_f === 1'b1))
            set_consec <= set_consec + 1;
        if ((rst_n && set !== 1'b1 && hp !== hp_prev) || (rst_n_f && set_f !== 1'b1 && hp_f !== hp_prev_f))
            hp_bad <= hp_bad + 1;
        set_prev   <= set;
        set_prev_f <= set_f;
        hp_prev    <= hp;
        hp_prev_f  <= hp_f;
    end

    task automatic pulses(input int n, input int first, input int half);
        for (int i = 0; i < n; i++) begin
            repeat ((i == 0) ? first : half) @(negedge clk);
            mod_in = ~mod_in;
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        mod_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hp !== 16'd0)  begin errors++; $display("FAIL reset_hp: got %0d want 0", hp); end
        checks++; if (set !== 1'b0)  begin errors++; $display("FAIL reset_set: got %b want 0", set); end
        checks++; if (lk !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %b want 0", lk); end
        checks++; if (lvl !== 1'b0)  begin errors++; $display("FAIL reset_level: got %b want 0", lvl); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        int s0;
        s0 = set_cnt;
        pulses(3, 400, 400);
        settle();
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL lock_early_locked: got %b want 0", lk); end
        checks++; if (set_cnt - s0 !== 0) begin errors++; $display("FAIL lock_early_set: got %0d pulses want 0", set_cnt - s0); end
        pulses(1, 394, 400);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL lock_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL lock_hp: got %0d want 99..101", hp); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", lk); end
        checks++; if (lvl !== mod_in) begin errors++; $display("FAIL lock_level: got %b want %b", lvl, mod_in); end
        pulses(20, 394, 400);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL steady_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL steady_locked: got %b want 1", lk); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL steady_hp: got %0d want 99..101", hp); end
    endtask

    task automatic test_switch();
        int s0;
        s0 = set_cnt;
        pulses(1, 194, 200);
        settle();
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL switch_unlock: got %b want 0", lk); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL switch_hold_hp: got %0d want 99..101", hp); end
        pulses(1, 194, 200);
        settle();
        checks++; if (set_cnt - s0 !== 0) begin errors++; $display("FAIL switch_early_set: got %0d pulses want 0", set_cnt - s0); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL switch_early_locked: got %b want 0", lk); end
        pulses(1, 194, 200);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL switch_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if ((hp >= 16'd49 && hp <= 16'd51) !== 1'b1) begin errors++; $display("FAIL switch_hp: got %0d want 49..51", hp); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL switch_locked: got %b want 1", lk); end
    endtask

    task automatic test_alternate();
        int s0;
        s0 = set_cnt;
        pulses(3, 394, 400);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL relock_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL relock_hp: got %0d want 99..101", hp); end
        s0 = set_cnt;
        for (int i = 0; i < 10; i++) begin
            pulses(1, (((i % 2) == 0) ? 404 : 400) - 6, 0);
            settle();
        end
        checks++; if (set_cnt - s0 !== 0) begin errors++; $display("FAIL alt_set: got %0d pulses want 0", set_cnt - s0); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL alt_locked: got %b want 1", lk); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL alt_hp: got %0d want 99..101", hp); end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = set_cnt;
        repeat (194) @(negedge clk);
        mod_in = ~mod_in;
        repeat (8) @(negedge clk);
        mod_in = ~mod_in;
        settle();
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL glitch_unlock: got %b want 0", lk); end
        repeat (186) @(negedge clk);
        mod_in = ~mod_in;
        settle();
        pulses(3, 394, 400);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL glitch_relock_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL glitch_relock_locked: got %b want 1", lk); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL glitch_relock_hp: got %0d want 99..101", hp); end
    endtask

    task automatic test_reset_mid();
        int s0;
        pulses(2, 194, 200);
        settle();
        mod_in = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (hp !== 16'd0) begin errors++; $display("FAIL midrst_hp: got %0d want 0", hp); end
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL midrst_set: got %b want 0", set); end
        checks++; if (lk !== 1'b0)  begin errors++; $display("FAIL midrst_locked: got %b want 0", lk); end
        checks++; if (lvl !== 1'b0) begin errors++; $display("FAIL midrst_level: got %b want 0", lvl); end
        @(negedge clk);
        rst_n = 1'b1;
        s0 = set_cnt;
        pulses(3, 400, 400);
        settle();
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL midrst_early_locked: got %b want 0", lk); end
        checks++; if (set_cnt - s0 !== 0) begin errors++; $display("FAIL midrst_early_set: got %0d pulses want 0", set_cnt - s0); end
        pulses(1, 394, 400);
        settle();
        checks++; if (set_cnt - s0 !== 1) begin errors++; $display("FAIL midrst_lock_set: got %0d pulses want 1", set_cnt - s0); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL midrst_lock_locked: got %b want 1", lk); end
        checks++; if ((hp >= 16'd99 && hp <= 16'd101) !== 1'b1) begin errors++; $display("FAIL midrst_lock_hp: got %0d want 99..101", hp); end
    endtask

    task automatic test_timeout();
        int   n;
        int   s0;
        logic done;
        rst_n_f = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_f = 1'b1;
        s0 = set_cnt_f;
        repeat (4) begin
            repeat (50) @(negedge clk);
            mod_in_f = ~mod_in_f;
        end
        n    = 0;
        done = 1'b0;
        while (!done && n < 70000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                checks++; if (lk_f !== 1'b1) begin errors++; $display("FAIL tmo_prelock: got %b want 1", lk_f); end
                checks++; if ((hp_f >= 16'd48 && hp_f <= 16'd50) !== 1'b1) begin errors++; $display("FAIL tmo_prelock_hp: got %0d want 48..50", hp_f); end
            end
            if (n > 10 && set_f === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || n < 65536 || n > 65544) begin
            errors++; $display("FAIL tmo_delay: got %0d clocks (seen=%b) want 65536..65544", n, done);
        end
        checks++; if (hp_f !== 16'd0) begin errors++; $display("FAIL tmo_hp: got %0d want 0", hp_f); end
        checks++; if (lk_f !== 1'b0)  begin errors++; $display("FAIL tmo_locked: got %b want 0", lk_f); end
        repeat (2000) @(negedge clk);
        checks++; if (set_cnt_f - s0 !== 2) begin errors++; $display("FAIL tmo_pulses: got %0d pulses want 2", set_cnt_f - s0); end
    endtask

    task automatic test_set_width();
        checks++; if (set_consec !== 0) begin errors++; $display("FAIL set_width: got %0d back-to-back strobes want 0", set_consec); end
        checks++; if (hp_bad !== 0) begin errors++; $display("FAIL hp_without_set: got %0d changes want 0", hp_bad); end
    endtask

    initial begin
        fork
            test_timeout();
            begin
                test_reset();
                test_lock();
                test_switch();
                test_alternate();
                test_glitch();
                test_reset_mid();
            end
        join
        test_set_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
